// File: rtl/demux1hot3_buf.sv
// demux1hot3_buf: single-entry buffer routing each beat to one of three outputs by one-hot select.
// Illegal selects are discarded, flagged on a sticky err and counted in a saturating drop_cnt.
module demux1hot3_buf #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       out_valid,
  input  logic [2:0]       out_ready,
  output logic             err,
  input  logic             err_clr,
  output logic [7:0]       drop_cnt
);
  logic [WIDTH-1:0] r_buf_data;
  logic [2:0]       r_buf_sel;
  logic             r_full;
  logic             r_err;
  logic [7:0]       r_drop_cnt;
  logic             w_drain;
  logic             w_accept;
  logic             w_legal;
  logic             w_load;
  logic             w_drop;
  always_comb begin
    w_drain  = r_full & |(r_buf_sel & out_ready);
    in_ready = ~r_full | w_drain;
    w_accept = in_valid & in_ready;
    w_legal  = (in_sel == 3'b001) | (in_sel == 3'b010) | (in_sel == 3'b100);
    w_load   = w_accept & w_legal;
    w_drop   = w_accept & ~w_legal;
    out_valid = r_full ? r_buf_sel : 3'b000;
    out_data  = r_buf_data;
    err       = r_err;
    drop_cnt  = r_drop_cnt;
  end
  // a dropped beat leaves full to the drain term, so a drain in the same cycle still empties the buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf_data <= '0;
      r_buf_sel  <= '0;
      r_full     <= 1'b0;
      r_err      <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_load) begin
        r_buf_data <= in_data;
        r_buf_sel  <= in_sel;
      end
      r_full <= w_load ? 1'b1 : (w_drain ? 1'b0 : r_full);
      r_err  <= w_drop ? 1'b1 : (err_clr ? 1'b0 : r_err);
      if (w_drop && r_drop_cnt != 8'hff) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_demux1hot3_buf.sv
// tb_demux1hot3_buf: scoreboard bench with directed scenarios and randomized traffic against a queue model.
module tb_demux1hot3_buf;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic [2:0] in_sel;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic [2:0] out_valid;
  logic [2:0] out_ready;
  logic       err;
  logic       err_clr;
  logic [7:0] drop_cnt;

  typedef struct {
    logic [7:0] d;
    logic [2:0] s;
  } beat_t;

  beat_t      sbq[$];
  int         n_assert = 0;
  int         n_fail = 0;
  bit         pend = 0;
  logic [2:0] pend_sel = '0;
  bit         m_err = 0;
  int         m_drop = 0;

  demux1hot3_buf #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .err(err), .err_clr(err_clr), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_assert++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  // monitor: compares each presented beat against the oldest expected beat
  always @(negedge clk) begin
    if (rst_n && out_valid != 3'b000) begin
      if (sbq.size() == 0) chk("spurious_out_valid", {29'd0, out_valid}, 32'd0);
      else begin
        chk("mon_out_valid", {29'd0, out_valid}, {29'd0, sbq[0].s});
        chk("mon_out_data", {24'd0, out_data}, {24'd0, sbq[0].d});
        if ((sbq[0].s & out_ready) != 3'b000) void'(sbq.pop_front());
      end
    end
  end

  function automatic bit legal(input logic [2:0] s);
    return $countones(s) == 1;
  endfunction

  task automatic cycle(input logic v, input logic [2:0] s, input logic [7:0] d,
                       input logic [2:0] r, input logic c);
    bit exp_rdy, acc, drn;
    in_valid = v; in_sel = s; in_data = d; out_ready = r; err_clr = c;
    #6;
    exp_rdy = !pend || ((pend_sel & r) != 3'b000);
    drn = pend && ((pend_sel & r) != 3'b000);
    acc = v && exp_rdy;
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    chk("out_valid", {29'd0, out_valid}, pend ? {29'd0, pend_sel} : 32'd0);
    chk("err", {31'd0, err}, {31'd0, m_err});
    chk("drop_cnt", {24'd0, drop_cnt}, m_drop);
    if (acc && legal(s)) begin
      pend = 1; pend_sel = s;
      sbq.push_back('{d: d, s: s});
    end else if (drn) pend = 0;
    if (acc && !legal(s)) begin
      m_err = 1;
      if (m_drop < 255) m_drop++;
    end else if (c) m_err = 0;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] bad_sel();
    logic [2:0] t;
    t = 3'($urandom_range(0, 7));
    while (legal(t)) t = 3'($urandom_range(0, 7));
    return t;
  endfunction

  initial begin
    logic [2:0] s;
    rst_n = 1'b0; in_valid = 0; in_sel = 0; in_data = 0; out_ready = 0; err_clr = 0;
    #3;
    chk("rst_out_valid", {29'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;
    // back-to-back routing
    cycle(1, 3'b001, 8'hA5, 3'b111, 0);
    cycle(1, 3'b100, 8'h3C, 3'b111, 0);
    cycle(1, 3'b010, 8'h7E, 3'b111, 0);
    cycle(0, 3'b000, 8'h00, 3'b111, 0);
    // backpressure
    cycle(1, 3'b010, 8'h11, 3'b101, 0);
    repeat (3) cycle(1, 3'b001, 8'hEE, 3'b101, 0);
    cycle(0, 3'b000, 8'h00, 3'b111, 0);
    cycle(0, 3'b000, 8'h00, 3'b111, 0);
    // simultaneous drain and fill
    cycle(1, 3'b001, 8'h44, 3'b000, 0);
    cycle(1, 3'b100, 8'h22, 3'b001, 0);
    cycle(0, 3'b000, 8'h00, 3'b100, 0);
    // illegal selects, set wins over clear, later clear alone
    cycle(1, 3'b000, 8'h01, 3'b111, 0);
    cycle(1, 3'b011, 8'h02, 3'b111, 0);
    cycle(1, 3'b110, 8'h03, 3'b111, 1);
    cycle(0, 3'b000, 8'h00, 3'b111, 1);
    cycle(0, 3'b000, 8'h00, 3'b111, 0);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      s = ($urandom_range(0, 9) == 0) ? bad_sel() : 3'(1 << $urandom_range(0, 2));
      cycle(1'($urandom_range(0, 3) != 0), s, 8'($urandom), 3'($urandom), 1'($urandom_range(0, 7) == 0));
    end
    cycle(0, 3'b000, 8'h00, 3'b111, 0);
    cycle(0, 3'b000, 8'h00, 3'b111, 0);
    // saturation
    for (int i = 0; i < 300; i++) cycle(1, bad_sel(), 8'($urandom), 3'b111, 0);
    cycle(0, 3'b000, 8'h00, 3'b111, 0);
    chk("drop_sat", {24'd0, drop_cnt}, 32'd255);
    // reset mid-cycle with the buffer full
    cycle(1, 3'b001, 8'h5A, 3'b000, 0);
    in_valid = 0; out_ready = 3'b000;
    #2 rst_n = 1'b0;
    #1;
    chk("amid_out_valid", {29'd0, out_valid}, 32'd0);
    chk("amid_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    chk("amid_err", {31'd0, err}, 32'd0);
    chk("amid_in_ready", {31'd0, in_ready}, 32'd1);
    chk("amid_out_data", {24'd0, out_data}, 32'd0);
    sbq.delete(); pend = 0; m_err = 0; m_drop = 0;
    @(posedge clk); #1;
    @(posedge clk); #1 rst_n = 1'b1;
    cycle(1, 3'b100, 8'h99, 3'b000, 0);
    cycle(0, 3'b000, 8'h00, 3'b100, 0);
    cycle(0, 3'b000, 8'h00, 3'b111, 0);
    chk("sb_empty", sbq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/demux1hot3_buf.md
DEMUX1HOT3_BUF -- requirements
Module: demux1hot3_buf

Interface
REQ-001 The module SHALL take one parameter: WIDTH, default 1, data width in bits.
REQ-002 The module SHALL have the port clk, input, 1 bit: the single clock. All state updates on the rising edge.
REQ-003 The module SHALL have the port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The module SHALL have the port in_data, input, WIDTH bits: upstream data beat.
REQ-005 The module SHALL have the port in_sel, input, 3 bits: one-hot destination; bit k selects output k.
REQ-006 The module SHALL have the port in_valid, input, 1 bit: upstream beat valid.
REQ-007 The module SHALL have the port in_ready, output, 1 bit: upstream beat accepted this cycle when in_valid is also high.
REQ-008 The module SHALL have the port out_data, output, WIDTH bits: buffered data, common to all three outputs.
REQ-009 The module SHALL have the port out_valid, output, 3 bits: per-output valid.
REQ-010 The module SHALL have the port out_ready, input, 3 bits: per-output ready.
REQ-011 The module SHALL have the port err, output, 1 bit: sticky flag for an illegal select.
REQ-012 The module SHALL have the port err_clr, input, 1 bit: synchronous clear of err.
REQ-013 The module SHALL have the port drop_cnt, output, 8 bits: count of dropped beats, saturating.

Function
REQ-014 The block SHALL hold a single-entry buffer made of buf_data (WIDTH bits), buf_sel (3 bits) and full (1 bit).
REQ-015 out_valid SHALL equal buf_sel gated by full; at most one out_valid bit is high in any cycle.
REQ-016 out_data SHALL equal buf_data, independent of which output is selected.
REQ-017 drain SHALL be defined as full AND OR-reduce(buf_sel AND out_ready); readiness of non-selected outputs SHALL be ignored.
REQ-018 in_ready SHALL be (NOT full) OR drain, combinationally, so the buffer is refilled in the same cycle it drains.
REQ-019 accept SHALL be in_valid AND in_ready; on accept of a legal select (exactly one bit of in_sel set), the block SHALL load buf_data and buf_sel and set full.
REQ-020 On accept of an illegal select (zero bits set, or two or more bits set), the block SHALL consume and discard the beat, set err, and increment drop_cnt. full SHALL then clear if drain, otherwise hold.
REQ-021 When drain occurs without accept, full SHALL clear; buf_data and buf_sel SHALL hold their values.
REQ-022 While out_valid is high and the selected out_ready is low, out_data and out_valid SHALL remain stable.
REQ-023 Latency SHALL be 1 cycle from accept to out_valid; sustained throughput SHALL be 1 beat per cycle while the selected destination is ready.
REQ-024 drop_cnt SHALL saturate at 255 and SHALL clear only on reset.
REQ-025 err SHALL clear on err_clr. If an illegal accept and err_clr occur in the same cycle, the set SHALL win and err SHALL read 1.
REQ-026 in_sel SHALL be ignored when in_valid is low; illegal-select detection SHALL apply only on accept.

Reset
REQ-027 On rst_n low, the block SHALL immediately set full=0, buf_data=0, buf_sel=0, err=0 and drop_cnt=0. Consequently out_valid=000, out_data=0 and in_ready=1.
REQ-028 Reset asserted mid-transfer SHALL discard the buffered beat without presenting it.
REQ-029 The first accept SHALL be possible on the first rising clk edge after rst_n deasserts.

Verification
REQ-030 The bench SHALL cover back-to-back routing. Stimulus: WIDTH=8, out_ready=111, beats A5/sel=001, 3C/sel=100, 7E/sel=010 on consecutive cycles. Response: out_valid=001, 100, 010 on the next three cycles with matching out_data; in_ready stays 1.
REQ-031 The bench SHALL cover backpressure. Stimulus: beat 11/sel=010 with out_ready=101 for 3 cycles, then 111. Response: out_valid=010 and out_data=11 held 4 cycles; in_ready=0 while held; drains on cycle 4.
REQ-032 The bench SHALL cover simultaneous drain and fill. Stimulus: buffer full with sel=001, out_ready=001, new beat 22/sel=100 presented. Response: in_ready=1 and the next cycle shows out_valid=100, out_data=22.
REQ-033 The bench SHALL cover illegal selects and error clearing. Stimulus: beats with sel=000 and then sel=011, then err_clr together with a further sel=110 beat. Response: no out_valid; drop_cnt=1, then 2, then 3; err stays 1 (set wins); a later err_clr alone gives err=0.
REQ-034 The bench SHALL cover saturation and reset. Stimulus: 300 illegal beats. Response: drop_cnt=255. Then, with the buffer full, assert rst_n low mid-cycle. Response: out_valid=000 and drop_cnt=0 without waiting for clk.
